// File: rtl/simple_alu.sv
// simple_alu: single-cycle-latency integer ALU with registered result,
// signed-less-than side output and V/C/N/Z flags.
module simple_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALUcontrol,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] slt,
    output logic             V,
    output logic             C,
    output logic             N,
    output logic             Z
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SLT  = 3'b101;
    localparam logic [2:0] OP_SLTU = 3'b110;
    localparam logic [2:0] OP_SLL  = 3'b111;

    logic             is_sub_s;
    logic [WIDTH-1:0] b_op_s;
    logic [WIDTH:0]   sum_s;
    logic             lt_signed_s;
    logic             lt_unsigned_s;
    logic             add_ovf_s;
    logic             sub_ovf_s;
    logic [WIDTH-1:0] result_nxt_s;
    logic [WIDTH-1:0] slt_nxt_s;
    logic             v_nxt_s;
    logic             c_nxt_s;

    logic [WIDTH-1:0] result_r;
    logic [WIDTH-1:0] slt_r;
    logic             v_r;
    logic             c_r;
    logic             n_r;
    logic             z_r;

    // Shared adder (subtract as A + ~B + 1), comparators and overflow terms.
    always_comb begin
        is_sub_s      = (ALUcontrol == OP_SUB);
        if (is_sub_s) begin
            b_op_s = ~B;
        end else begin
            b_op_s = B;
        end
        sum_s         = {1'b0, A} + {1'b0, b_op_s} + {{WIDTH{1'b0}}, is_sub_s};
        // Direct signed compare: immune to overflow of the subtraction sign.
        lt_signed_s   = ($signed(A) < $signed(B));
        lt_unsigned_s = (A < B);
        add_ovf_s     = (A[WIDTH-1] == B[WIDTH-1]) && (sum_s[WIDTH-1] != A[WIDTH-1]);
        sub_ovf_s     = (A[WIDTH-1] != B[WIDTH-1]) && (sum_s[WIDTH-1] != A[WIDTH-1]);
        slt_nxt_s     = {{(WIDTH-1){1'b0}}, lt_signed_s};
    end

    // Opcode decode selecting the next result and arithmetic flags.
    always_comb begin
        result_nxt_s = {WIDTH{1'b0}};
        v_nxt_s      = 1'b0;
        c_nxt_s      = 1'b0;
        case (ALUcontrol)
            OP_ADD: begin
                result_nxt_s = sum_s[WIDTH-1:0];
                c_nxt_s      = sum_s[WIDTH];
                v_nxt_s      = add_ovf_s;
            end
            OP_SUB: begin
                result_nxt_s = sum_s[WIDTH-1:0];
                c_nxt_s      = sum_s[WIDTH];
                v_nxt_s      = sub_ovf_s;
            end
            OP_AND:  result_nxt_s = A & B;
            OP_OR:   result_nxt_s = A | B;
            OP_XOR:  result_nxt_s = A ^ B;
            OP_SLT:  result_nxt_s = {{(WIDTH-1){1'b0}}, lt_signed_s};
            OP_SLTU: result_nxt_s = {{(WIDTH-1){1'b0}}, lt_unsigned_s};
            OP_SLL:  result_nxt_s = A << B[4:0];
            default: begin
                result_nxt_s = {WIDTH{1'b0}};
                v_nxt_s      = 1'b0;
                c_nxt_s      = 1'b0;
            end
        endcase
    end

    // Output register; reset clears everything and discards in-flight results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_r <= {WIDTH{1'b0}};
            slt_r    <= {WIDTH{1'b0}};
            v_r      <= 1'b0;
            c_r      <= 1'b0;
            n_r      <= 1'b0;
            z_r      <= 1'b0;
        end else begin
            result_r <= result_nxt_s;
            slt_r    <= slt_nxt_s;
            v_r      <= v_nxt_s;
            c_r      <= c_nxt_s;
            n_r      <= result_nxt_s[WIDTH-1];
            z_r      <= (result_nxt_s == {WIDTH{1'b0}});
        end
    end

    assign Result = result_r;
    assign slt    = slt_r;
    assign V      = v_r;
    assign C      = c_r;
    assign N      = n_r;
    assign Z      = z_r;

endmodule

// File: tb/tb_simple_alu.sv
// Scoreboard bench for simple_alu: expected values are pushed when an
// operation is driven and popped one cycle later when the DUT output is due.
module tb_simple_alu;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] result;
    logic [31:0] slt_o;
    logic        v, c, n, z;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] r;
        logic [31:0] s;
        logic        v;
        logic        c;
        logic        n;
        logic        z;
    } exp_t;

    exp_t sb[$];

    simple_alu #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (a),
        .B         (b),
        .ALUcontrol(op),
        .Result    (result),
        .slt       (slt_o),
        .V         (v),
        .C         (c),
        .N         (n),
        .Z         (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model built from wide signed/unsigned integer arithmetic.
    function automatic exp_t model(input logic [31:0] ia, input logic [31:0] ib, input logic [2:0] iop);
        exp_t   e;
        longint sa;
        longint sb_v;
        longint t;
        logic [32:0] wide;
        sa   = longint'($signed(ia));
        sb_v = longint'($signed(ib));
        e    = '0;
        case (iop)
            3'd0: begin
                wide = {1'b0, ia} + {1'b0, ib};
                e.r  = wide[31:0];
                e.c  = wide[32];
                t    = sa + sb_v;
                e.v  = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            3'd1: begin
                e.r  = ia - ib;
                e.c  = (ia >= ib);
                t    = sa - sb_v;
                e.v  = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            3'd2: e.r = ia & ib;
            3'd3: e.r = ia | ib;
            3'd4: e.r = ia ^ ib;
            3'd5: e.r = (sa < sb_v) ? 32'd1 : 32'd0;
            3'd6: e.r = (ia < ib) ? 32'd1 : 32'd0;
            default: e.r = ia << ib[4:0];
        endcase
        e.s = (sa < sb_v) ? 32'd1 : 32'd0;
        e.n = e.r[31];
        e.z = (e.r == 32'd0);
        return e;
    endfunction

    task automatic compare_outputs(input string tag, input exp_t e);
        check_val({tag, ".result"}, result, e.r);
        check_val({tag, ".slt"},    slt_o,  e.s);
        check_val({tag, ".V"},      {31'd0, v}, {31'd0, e.v});
        check_val({tag, ".C"},      {31'd0, c}, {31'd0, e.c});
        check_val({tag, ".N"},      {31'd0, n}, {31'd0, e.n});
        check_val({tag, ".Z"},      {31'd0, z}, {31'd0, e.z});
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, ".result"}, result, 32'd0);
        check_val({tag, ".slt"},    slt_o,  32'd0);
        check_val({tag, ".flags"},  {28'd0, v, c, n, z}, 32'd0);
    endtask

    // One cycle at the falling edge: check the due result, then drive the next op.
    task automatic cycle(input logic [31:0] ia, input logic [31:0] ib, input logic [2:0] iop);
        exp_t e;
        @(negedge clk);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            compare_outputs("op", e);
        end
        a  = ia;
        b  = ib;
        op = iop;
        sb.push_back(model(ia, ib, iop));
    endtask

    task automatic drain();
        exp_t e;
        @(negedge clk);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            compare_outputs("drain", e);
        end
    endtask

    logic [31:0] corners [6];

    initial begin
        corners[0] = 32'h0000_0000;
        corners[1] = 32'h0000_0001;
        corners[2] = 32'h7FFF_FFFF;
        corners[3] = 32'h8000_0000;
        corners[4] = 32'hFFFF_FFFF;
        corners[5] = 32'h0000_001F;

        rst_n = 1'b0;
        a  = 32'h1234_5678;
        b  = 32'h0000_0003;
        op = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset_hold");

        @(negedge clk);
        rst_n = 1'b1;

        // Basic sequence ADD/SUB/AND/OR on 10,5.
        cycle(32'd10, 32'd5, 3'd0);
        cycle(32'd10, 32'd5, 3'd1);
        cycle(32'd10, 32'd5, 3'd2);
        cycle(32'd10, 32'd5, 3'd3);
        // SLT / SLTU across sign, overflow and borrow cases.
        cycle(32'd5, 32'd10, 3'd5);
        cycle(32'hFFFF_FFFF, 32'd1, 3'd6);
        cycle(32'h8000_0000, 32'd1, 3'd5);
        cycle(32'h7FFF_FFFF, 32'd1, 3'd0);
        cycle(32'd5, 32'd10, 3'd1);
        cycle(32'd15, 32'd15, 3'd1);
        cycle(32'h8000_0000, 32'd1, 3'd1);
        cycle(32'hFFFF_FFFF, 32'd1, 3'd0);
        cycle(32'hA5A5_0F0F, 32'h0000_0000, 3'd7);
        cycle(32'h0000_0001, 32'hFFFF_FFFF, 3'd7);
        cycle(32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd4);

        // Explicit hand-derived checks for a few key vectors.
        cycle(32'h7FFF_FFFF, 32'd1, 3'd0);
        @(negedge clk);
        check_val("ovf.result", result, 32'h8000_0000);
        check_val("ovf.VNCZ", {28'd0, v, n, c, z}, {28'd0, 4'b1100});
        void'(sb.pop_front());
        a = 32'd5; b = 32'd10; op = 3'd1;
        sb.push_back(model(32'd5, 32'd10, 3'd1));
        @(negedge clk);
        check_val("borrow.result", result, 32'hFFFF_FFFB);
        check_val("borrow.VNCZ", {28'd0, v, n, c, z}, {28'd0, 4'b0100});
        void'(sb.pop_front());

        // Back-to-back random traffic mixing corner and random operands.
        for (int i = 0; i < 80; i++) begin
            logic [31:0] ra, rb;
            ra = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            rb = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            cycle(ra, rb, 3'($urandom_range(0, 7)));
        end

        // Mid-stream asynchronous reset between clock edges.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_async");
        sb.delete();
        @(posedge clk);
        #1;
        check_all_zero("rst_edge");
        @(negedge clk);
        rst_n = 1'b1;
        a  = 32'd20;
        b  = 32'd22;
        op = 3'd0;
        sb.push_back(model(32'd20, 32'd22, 3'd0));
        cycle(32'd3, 32'd7, 3'd5);
        cycle(32'h0000_0003, 32'd4, 3'd7);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/simple_alu.md
SIMPLE_ALU -- requirements
Module: simple_alu

Interface
REQ-001 Parameter: WIDTH, default 32, datapath width in bits; all data ports below are WIDTH bits wide.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-003 clk  input  1  rising-edge clock; all outputs SHALL be registered on this edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 A  input  WIDTH  operand A, two's complement for signed ops.
REQ-006 B  input  WIDTH  operand B, two's complement for signed ops.
REQ-007 ALUcontrol  input  3  operation select.
REQ-008 Result  output  WIDTH  registered operation result.
REQ-009 slt  output  WIDTH  registered signed-less-than indicator: bit 0 = (A <s B), upper bits 0, for every opcode.
REQ-010 V  output  1  registered signed overflow flag.
REQ-011 C  output  1  registered carry flag.
REQ-012 N  output  1  registered negative flag.
REQ-013 Z  output  1  registered zero flag.

Function
REQ-014 Opcodes SHALL be: 000 ADD A+B; 001 SUB A-B; 010 AND; 011 OR; 100 XOR; 101 SLT (signed, zero-extended 0/1); 110 SLTU (unsigned, zero-extended 0/1); 111 SLL A << B[4:0].
REQ-015 Latency SHALL be exactly one clock: inputs sampled at edge k appear on all outputs after edge k; a new operation is accepted every cycle; there is no handshake.
REQ-016 Arithmetic SHALL be modulo 2^WIDTH; the sum is computed WIDTH+1 bits wide internally.
REQ-017 SUB SHALL be computed as A + ~B + 1.
REQ-018 C SHALL equal the carry out of bit WIDTH-1 for ADD and SUB; for SUB, C=1 means no borrow (A >=u B). C SHALL be 0 for all other opcodes.
REQ-019 V SHALL be 1 for ADD when A and B have equal sign bits and the sign of Result differs from them.
REQ-020 V SHALL be 1 for SUB when A and B have different sign bits and the sign of Result differs from A's.
REQ-021 V SHALL be 0 for all other opcodes.
REQ-022 N SHALL equal Result[WIDTH-1], and Z SHALL equal (Result == 0), for every opcode, both taken from the registered result.
REQ-023 SLT SHALL be correct across sign boundaries (e.g. 0x80000000 <s 0x00000001 gives 1) and SHALL NOT use the possibly overflowed subtraction sign alone.
REQ-024 The slt output SHALL be updated every cycle, independent of ALUcontrol.
REQ-025 SLL SHALL use only B[4:0]; shift amount 0 returns A unchanged.
REQ-026 Output and flag behaviour SHALL be fully defined for all 8 opcodes; no X outputs may occur for known inputs.

Reset
REQ-027 While rst_n=0, Result, slt, V, C, N and Z SHALL be 0, asserted asynchronously without waiting for a clock edge.
REQ-028 The first valid output SHALL appear one edge after the first rising clk edge with rst_n=1.
REQ-029 Reset asserted mid-stream SHALL discard any in-flight result.

Verification
REQ-030 A=10, B=5, sequential opcodes ADD/SUB/AND/OR -> Result 15 / 5 (C=1) / 0 (Z=1) / 15, each one cycle after it is applied.
REQ-031 SLT, A=5, B=10 -> Result=1, slt=1, N=0, Z=0; SLTU, A=0xFFFFFFFF, B=1 -> Result=0, while slt=1.
REQ-032 ADD, A=0x7FFFFFFF, B=1 -> Result=0x80000000, V=1, N=1, C=0, Z=0.
REQ-033 SUB, A=5, B=10 -> Result=0xFFFFFFFB, N=1, C=0, V=0; SUB, A=15, B=15 -> Result=0, Z=1, C=1.
REQ-034 Back-to-back opcode changes every cycle -> each result aligned exactly one cycle later, with no bubbles.
REQ-035 Assert rst_n=0 between clock edges during active traffic -> all outputs 0 immediately; resume after release with one-cycle latency.
